// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between four requesters and the round-robin arbiter.
// master = requester side, slave = arbiter side.
interface rr_arbiter4_if;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    modport master (
        output req,
        output done,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output gnt,
        output gnt_idx,
        output gnt_valid,
        output timeout
    );
endinterface

// File: rtl/rr_arbiter4.sv
// Purpose: 4-way round-robin arbiter with a two-state IDLE/GRANT FSM and a rotating priority pointer.
// Latency: grant visible one cycle after the request edge; at least one idle cycle between grants.
// Backpressure: owner keeps the grant until done, request drop or (ARB_TIMEOUT_EN) timeout expiry.
module rr_arbiter4 #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic         clk,
    input  logic         rst,
    rr_arbiter4_if.slave bus
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_ptr;
    logic [1:0] w_ptr_nxt;
    logic [3:0] r_gnt;
    logic [3:0] w_gnt_nxt;
    logic [1:0] r_gnt_idx;
    logic [1:0] w_gnt_idx_nxt;
    logic       r_gnt_valid;
    logic       w_gnt_valid_nxt;
    logic       r_timeout;
    logic       w_timeout_nxt;

    logic       w_win_vld;
    logic [1:0] w_win_idx;
    logic       w_norm_rel;
    logic       w_expire;

    // Scan from the lowest priority up so the highest-priority hit is written last.
    always_comb begin
        w_win_vld = 1'b0;
        w_win_idx = 2'b00;
        for (int k = 3; k >= 0; k--) begin
            if (bus.req[r_ptr + 2'(k)]) begin
                w_win_vld = 1'b1;
                w_win_idx = r_ptr + 2'(k);
            end
        end
    end

    assign w_norm_rel = bus.done | ~bus.req[r_gnt_idx];

`ifdef ARB_TIMEOUT_EN
    logic [7:0] r_cnt;

    // Counter reads 0 in the first grant cycle, so it hits TIMEOUT_CYCLES-1 in the last allowed one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 8'd0;
        end else if (r_state == S_GRANT) begin
            r_cnt <= r_cnt + 8'd1;
        end else begin
            r_cnt <= 8'd0;
        end
    end

    assign w_expire = (r_state == S_GRANT) && (r_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
    logic [7:0] w_unused_cfg;

    assign w_unused_cfg = 8'(TIMEOUT_CYCLES);
    assign w_expire     = 1'b0;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_gnt_nxt       = r_gnt;
        w_gnt_idx_nxt   = r_gnt_idx;
        w_gnt_valid_nxt = r_gnt_valid;
        w_timeout_nxt   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_win_vld) begin
                    w_state_nxt     = S_GRANT;
                    w_gnt_nxt       = 4'b0001 << w_win_idx;
                    w_gnt_idx_nxt   = w_win_idx;
                    w_gnt_valid_nxt = 1'b1;
                end else begin
                    w_gnt_nxt       = 4'b0000;
                    w_gnt_idx_nxt   = 2'b00;
                    w_gnt_valid_nxt = 1'b0;
                end
            end
            S_GRANT: begin
                // A normal release masks a coincident expiry, so timeout only fires on a forced revoke.
                if (w_norm_rel || w_expire) begin
                    w_state_nxt     = S_IDLE;
                    w_ptr_nxt       = r_gnt_idx + 2'd1;
                    w_gnt_nxt       = 4'b0000;
                    w_gnt_idx_nxt   = 2'b00;
                    w_gnt_valid_nxt = 1'b0;
                    w_timeout_nxt   = w_expire & ~w_norm_rel;
                end
            end
            default: begin
                w_state_nxt     = S_IDLE;
                w_gnt_nxt       = 4'b0000;
                w_gnt_idx_nxt   = 2'b00;
                w_gnt_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= 2'b00;
            r_gnt       <= 4'b0000;
            r_gnt_idx   <= 2'b00;
            r_gnt_valid <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_gnt       <= w_gnt_nxt;
            r_gnt_idx   <= w_gnt_idx_nxt;
            r_gnt_valid <= w_gnt_valid_nxt;
            r_timeout   <= w_timeout_nxt;
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.gnt_idx   = r_gnt_idx;
    assign bus.gnt_valid = r_gnt_valid;
    assign bus.timeout   = r_timeout;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Bench for rr_arbiter4: directed sequences with literal expectations plus a random run
// compared every cycle against an owner/pointer model of the round-robin rules.
module tb_rr_arbiter4;

    localparam int TCYC = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rr_arbiter4_if bus();

    rr_arbiter4 #(.TIMEOUT_CYCLES(TCYC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: owner (-1 = none), priority pointer, cycles the current grant has been visible.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_held  = 0;
    bit m_tmo   = 1'b0;
    bit m_live  = 1'b0;
    int wait_cnt [4];

    always @(posedge clk) begin : model
        logic [3:0] rq;
        logic       dn;
        bit         normal;
        bit         expire;
        int         c;
        logic [3:0] e_gnt;
        logic [1:0] enc;

        rq = bus.req;
        dn = bus.done;
        if (rst) begin
            m_owner = -1;
            m_ptr   = 0;
            m_held  = 0;
            m_tmo   = 1'b0;
            m_live  = 1'b1;
            for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
        end else if (m_live) begin
            for (int i = 0; i < 4; i++) if (!rq[i]) wait_cnt[i] = 0;
            m_tmo = 1'b0;
            if (m_owner < 0) begin
                for (int k = 0; k < 4; k++) begin
                    c = (m_ptr + k) % 4;
                    if (m_owner < 0 && rq[c]) m_owner = c;
                end
                if (m_owner >= 0) begin
                    m_held = 1;
                    for (int i = 0; i < 4; i++) begin
                        if (i != m_owner && rq[i]) begin
                            wait_cnt[i]++;
                            chk("starve", (wait_cnt[i] > 3) ? 8'd1 : 8'd0, 8'd0);
                        end
                    end
                    wait_cnt[m_owner] = 0;
                end
            end else begin
                normal = dn || !rq[m_owner];
                expire = TMO_EN && (m_held == TCYC);
                if (normal || expire) begin
                    m_tmo   = expire && !normal;
                    m_ptr   = (m_owner + 1) % 4;
                    m_owner = -1;
                end else begin
                    m_held++;
                end
            end
        end

        #1;
        if (m_live) begin
            e_gnt = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
            chk("gnt", {4'b0, bus.gnt}, {4'b0, e_gnt});
            chk("gnt_idx", {6'b0, bus.gnt_idx}, (m_owner >= 0) ? 8'(m_owner) : 8'd0);
            chk("gnt_valid", {7'b0, bus.gnt_valid}, (m_owner >= 0) ? 8'd1 : 8'd0);
            chk("timeout", {7'b0, bus.timeout}, {7'b0, m_tmo});
            enc = 2'b00;
            for (int i = 0; i < 4; i++) if (bus.gnt[i]) enc = 2'(i);
            chk("onehot", ($countones(bus.gnt) <= 1) ? 8'd1 : 8'd0, 8'd1);
            chk("idx_enc", {6'b0, bus.gnt_idx}, {6'b0, enc});
            chk("valid_or", {7'b0, bus.gnt_valid}, {7'b0, |bus.gnt});
        end
    end

    task automatic cyc(input logic r, input logic [3:0] rq, input logic dn);
        @(negedge clk);
        rst      = r;
        bus.req  = rq;
        bus.done = dn;
        @(posedge clk);
        #2;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] seq [5];
        logic [3:0] rq;
        logic [3:0] flip;
        int         n;

        rst      = 1'b1;
        bus.req  = 4'b0000;
        bus.done = 1'b0;
        seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;

        // Reset with all inputs active must still give all-zero outputs.
        cyc(1'b1, 4'b1111, 1'b1);
        chk("rst_gnt", {4'b0, bus.gnt}, 8'h00);
        chk("rst_idx", {6'b0, bus.gnt_idx}, 8'h00);
        chk("rst_valid", {7'b0, bus.gnt_valid}, 8'h00);
        chk("rst_timeout", {7'b0, bus.timeout}, 8'h00);

        // done while idle is ignored: the request is still granted.
        cyc(1'b0, 4'b0010, 1'b1);
        chk("idle_done_gnt", {4'b0, bus.gnt}, 8'h02);
        cyc(1'b0, 4'b0010, 1'b1);
        chk("idle_done_rel", {7'b0, bus.gnt_valid}, 8'h00);

        // Full rotation with all requesters active.
        cyc(1'b1, 4'b0000, 1'b0);
        for (int j = 0; j < 5; j++) begin
            cyc(1'b0, 4'b1111, 1'b0);
            chk("rot_gnt", {4'b0, bus.gnt}, {4'b0, seq[j]});
            cyc(1'b0, 4'b1111, 1'b1);
            chk("rot_gap", {7'b0, bus.gnt_valid}, 8'h00);
        end

        // Single request, release by request drop, pointer moves to 3.
        cyc(1'b1, 4'b0000, 1'b0);
        cyc(1'b0, 4'b0100, 1'b0);
        chk("single_gnt", {4'b0, bus.gnt}, 8'h04);
        chk("single_idx", {6'b0, bus.gnt_idx}, 8'h02);
        chk("single_valid", {7'b0, bus.gnt_valid}, 8'h01);
        cyc(1'b0, 4'b0000, 1'b0);
        chk("drop_gnt", {4'b0, bus.gnt}, 8'h00);
        cyc(1'b0, 4'b1001, 1'b0);
        chk("ptr3_idx", {6'b0, bus.gnt_idx}, 8'h03);
        chk("ptr3_gnt", {4'b0, bus.gnt}, 8'h08);

        // Reset mid-grant, then pointer restarts at 0.
        cyc(1'b1, 4'b1010, 1'b0);
        chk("midrst_gnt", {4'b0, bus.gnt}, 8'h00);
        chk("midrst_valid", {7'b0, bus.gnt_valid}, 8'h00);
        cyc(1'b0, 4'b1010, 1'b0);
        chk("postrst_idx", {6'b0, bus.gnt_idx}, 8'h01);

        // Owner 1 holds while everyone requests; no preemption.
        n = TMO_EN ? TCYC - 1 : 20;
        for (int j = 0; j < n; j++) begin
            cyc(1'b0, 4'b1111, 1'b0);
            chk("hold_gnt", {4'b0, bus.gnt}, 8'h02);
        end
        cyc(1'b0, 4'b1111, 1'b1);
        chk("hold_rel", {7'b0, bus.gnt_valid}, 8'h00);
        chk("hold_rel_tmo", {7'b0, bus.timeout}, 8'h00);

`ifdef ARB_TIMEOUT_EN
        cyc(1'b1, 4'b0000, 1'b0);
        cyc(1'b0, 4'b0001, 1'b0);
        chk("tmo_first", {7'b0, bus.gnt_valid}, 8'h01);
        for (int j = 0; j < TCYC - 1; j++) begin
            cyc(1'b0, 4'b0001, 1'b0);
            chk("tmo_hold", {7'b0, bus.gnt_valid}, 8'h01);
            chk("tmo_quiet", {7'b0, bus.timeout}, 8'h00);
        end
        cyc(1'b0, 4'b0001, 1'b0);
        chk("tmo_fall", {7'b0, bus.gnt_valid}, 8'h00);
        chk("tmo_pulse", {7'b0, bus.timeout}, 8'h01);
        cyc(1'b0, 4'b0001, 1'b0);
        chk("tmo_regrant", {4'b0, bus.gnt}, 8'h01);
        chk("tmo_clear", {7'b0, bus.timeout}, 8'h00);
        cyc(1'b0, 4'b0001, 1'b1);
`endif

        // Random traffic: sticky requests with occasional toggles.
        rq = 4'b0000;
        for (int j = 0; j < 10000; j++) begin
            flip = 4'b0000;
            for (int b = 0; b < 4; b++) flip[b] = ($urandom_range(0, 7) == 0);
            rq = rq ^ flip;
            cyc(($urandom_range(0, 499) == 0), rq, ($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_arbiter4.md
RR_ARBITER4 -- requirements
Module: rr_arbiter4

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 16, maximum grant length in cycles (range 2..255); used only when ARB_TIMEOUT_EN is defined.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req  input  4  request lines; bit i = requester i wants the shared resource.
REQ-005 done  input  1  current owner releases the resource; sampled only while gnt_valid=1.
REQ-006 gnt  output  4  one-hot grant; all-zero when no owner; registered.
REQ-007 gnt_idx  output  2  binary index of the owner; equals the 4-to-2 encoding of gnt; 2'b00 when gnt_valid=0; registered.
REQ-008 gnt_valid  output  1  high while an owner holds the grant; registered.
REQ-009 timeout  output  1  one-cycle pulse when a grant is forcibly revoked; registered.

Function
REQ-010 The FSM shall have exactly two states: IDLE (no owner) and GRANT (one owner).
REQ-011 Priority pointer ptr[1:0] marks the highest-priority requester; search order shall be ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-012 IDLE with req!=0 at edge N: winner = first set bit in search order; state=GRANT, gnt=one-hot(winner), gnt_idx=winner, gnt_valid=1, all visible after edge N (one-cycle latency).
REQ-013 IDLE with req==0: state, ptr and outputs shall remain unchanged, with all outputs zero.
REQ-014 GRANT: gnt, gnt_idx and gnt_valid shall hold constant until a release condition occurs.
REQ-015 Release conditions, any of which suffices: done=1; req[gnt_idx]=0; timeout expiry (REQ-024).
REQ-016 On release at edge N: state=IDLE, gnt=0, gnt_idx=0, gnt_valid=0 after edge N, and ptr=gnt_idx+1 (mod 4).
REQ-017 Turnaround: after a release, at least one cycle with gnt_valid=0 shall precede the next grant; back-to-back grants are prohibited.
REQ-018 Requests arriving or changing while in GRANT shall not preempt the owner; only req[owner] is observed.
REQ-019 done=1 while in IDLE shall be ignored.
REQ-020 Simultaneous done=1 and req[owner]=0 counts as a single release, with ptr advanced once.
REQ-021 ptr wraps: owner 3 released -> ptr=0.
REQ-022 gnt shall never have more than one bit set; gnt_valid shall equal |gnt in every cycle.

Reset
REQ-023 rst=1 at an edge, in any state including mid-grant, shall set state=IDLE, ptr=0, gnt=0, gnt_idx=0, gnt_valid=0, timeout=0, and timeout counter=0; rst has priority over all other inputs.

Configuration
REQ-024 With macro ARB_TIMEOUT_EN defined: an 8-bit counter shall clear on grant entry and increment each GRANT cycle. If the grant is still held TIMEOUT_CYCLES cycles after gnt_valid rose, the block shall release per REQ-016 and pulse timeout=1 for exactly one cycle, coincident with gnt_valid falling.
REQ-025 With ARB_TIMEOUT_EN defined, if a normal release and expiry coincide, the release shall be treated as normal and timeout shall stay 0.
REQ-026 With ARB_TIMEOUT_EN undefined: no counter shall be built, timeout shall be tied to 0, grants shall be unbounded, and the port list shall be unchanged.

Verification
REQ-027 Apply rst, then req=4'b1111 held and done pulsed each grant -> grant sequence 0,1,2,3,0 (gnt 0001,0010,0100,1000,0001), each grant separated by one gnt_valid=0 cycle.
REQ-028 req=4'b0100 from IDLE -> one cycle later gnt=0100, gnt_idx=2'b10, gnt_valid=1; then req=4'b0000 -> next cycle gnt=0, and ptr=3 verified by next req=4'b1001 granting idx 3.
REQ-029 Owner idx 1 holding; raise req=4'b1111 without done -> gnt stays 0010 for 20 cycles (macro undefined), no preemption.
REQ-030 ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=4: req=4'b0001 held, done=0 -> gnt_valid high exactly 4 cycles, timeout=1 for 1 cycle as gnt_valid falls; next grant idx 0 after turnaround.
REQ-031 rst=1 asserted mid-grant with gnt=1000 -> next cycle all outputs 0; with req=4'b1010, the first grant after reset is idx 1 (ptr=0).
REQ-032 Random req/done for 10000 cycles -> gnt one-hot or zero, gnt_idx==encode(gnt), gnt_valid==|gnt every cycle, and no requester held continuously asserted waits more than 3 grants.
